// File: rtl/live_window_gen_pkg.sv
// Shared types and sizing helpers for the multi-channel live-window generator.
package live_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_LIVE  = 2'd2
  } state_t;

  // Tick counter must hold the larger of the two unit fields scaled by the prescaler.
  function automatic int cnt_width(input int len_w, input int delay_w, input int prescale_log2);
    return prescale_log2 + ((len_w > delay_w) ? len_w : delay_w);
  endfunction

endpackage

// File: rtl/live_window_gen_if.sv
// Control/status bundle of the live-window generator; master drives strobes and config.
// Handshake: strobes are sampled on every rising clk edge (no valid/ready); outputs are registered.
interface live_window_gen_if #(
  parameter int NCH     = 4,
  parameter int LEN_W   = 8,
  parameter int DELAY_W = 8
);
  logic [NCH-1:0]         in_start;
  logic [NCH-1:0]         in_abort;
  logic [NCH*LEN_W-1:0]   cfg_length;
  logic [NCH*DELAY_W-1:0] cfg_delay;
  logic [NCH-1:0]         cfg_retrig;
  logic [NCH-1:0]         out_live;
  logic [NCH-1:0]         out_done;
  logic [NCH-1:0]         out_busy;
  logic                   out_any_live;
  logic [2*NCH-1:0]       dbg_state;

  modport master (
    output in_start, in_abort, cfg_length, cfg_delay, cfg_retrig,
    input  out_live, out_done, out_busy, out_any_live, dbg_state
  );

  modport slave (
    input  in_start, in_abort, cfg_length, cfg_delay, cfg_retrig,
    output out_live, out_done, out_busy, out_any_live, dbg_state
  );
endinterface

// File: rtl/live_window_gen_chan.sv
// One channel: IDLE/DELAY/LIVE FSM driven by a single prescaled down-counter.
module live_window_chan
  import live_gen_pkg::*;
#(
  parameter int LEN_W         = 8,
  parameter int DELAY_W       = 8,
  parameter int PRESCALE_LOG2 = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   length,
  input  logic [DELAY_W-1:0] delay,
  input  logic               retrig,
  output logic               live,
  output logic               done,
  output logic               busy,
  output state_t             state
);
  localparam int CW = cnt_width(LEN_W, DELAY_W, PRESCALE_LOG2);

  logic [CW-1:0]    cnt;
  logic [LEN_W-1:0] len_q;
  logic             retrig_q;
  logic [CW-1:0]    len_ticks;
  logic [CW-1:0]    dly_ticks;
  logic [CW-1:0]    lat_ticks;
  logic             accept;

  // Phase lengths are loaded as ticks-1 so a phase ends on the cycle the counter reads zero.
  assign len_ticks = (CW'(length) << PRESCALE_LOG2) - CW'(1);
  assign dly_ticks = (CW'(delay)  << PRESCALE_LOG2) - CW'(1);
  assign lat_ticks = (CW'(len_q)  << PRESCALE_LOG2) - CW'(1);
  assign accept    = start && (length != '0) && ((state == ST_IDLE) || retrig_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      retrig_q <= 1'b0;
      live     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        cnt   <= '0;
        live  <= 1'b0;
        busy  <= 1'b0;
      end else if (accept) begin
        len_q    <= length;
        retrig_q <= retrig;
        busy     <= 1'b1;
        if (delay != '0) begin
          state <= ST_DELAY;
          cnt   <= dly_ticks;
          live  <= 1'b0;
        end else begin
          state <= ST_LIVE;
          cnt   <= len_ticks;
          live  <= 1'b1;
        end
      end else begin
        case (state)
          ST_DELAY: begin
            if (cnt == '0) begin
              state <= ST_LIVE;
              cnt   <= lat_ticks;
              live  <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_LIVE: begin
            if (cnt == '0) begin
              state <= ST_IDLE;
              live  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/live_window_gen.sv
// NCH independent live-window channels plus a registered any-live summary.
module live_window_gen
  import live_gen_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int LEN_W         = 8,
  parameter int DELAY_W       = 8,
  parameter int PRESCALE_LOG2 = 23
) (
  input logic             clk,
  input logic             rst_n,
  live_window_gen_if.slave bus
);
  logic [NCH-1:0] live_vec;
  logic [NCH-1:0] done_vec;
  logic [NCH-1:0] busy_vec;
  state_t         st [NCH];
  logic           any_live_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    live_window_chan #(
      .LEN_W        (LEN_W),
      .DELAY_W      (DELAY_W),
      .PRESCALE_LOG2(PRESCALE_LOG2)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bus.in_start[i]),
      .abort (bus.in_abort[i]),
      .length(bus.cfg_length[i*LEN_W +: LEN_W]),
      .delay (bus.cfg_delay[i*DELAY_W +: DELAY_W]),
      .retrig(bus.cfg_retrig[i]),
      .live  (live_vec[i]),
      .done  (done_vec[i]),
      .busy  (busy_vec[i]),
      .state (st[i])
    );
    assign bus.dbg_state[2*i +: 2] = st[i];
  end

  // Summary lags out_live by one edge so it is a clean register, not an OR of outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_live_q <= 1'b0;
    else        any_live_q <= |live_vec;
  end

  assign bus.out_live     = live_vec;
  assign bus.out_done     = done_vec;
  assign bus.out_busy     = busy_vec;
  assign bus.out_any_live = any_live_q;

endmodule

// File: tb/tb_live_window_gen.sv
// Directed bench for live_window_gen with PRESCALE_LOG2=2 (one unit = 4 cycles), NCH=4.
module tb_live_window_gen;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  live_window_gen_if #(.NCH(4), .LEN_W(8), .DELAY_W(8)) bus ();

  live_window_gen #(
    .NCH(4), .LEN_W(8), .DELAY_W(8), .PRESCALE_LOG2(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_len(input int ch, input int v);
    bus.cfg_length[ch*8 +: 8] = 8'(v);
  endtask

  task automatic set_dly(input int ch, input int v);
    bus.cfg_delay[ch*8 +: 8] = 8'(v);
  endtask

  // Cycle c is the interval after the c-th edge; sampling happens #1 past that edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.out_live !== 4'b0) begin errors++; $display("FAIL reset live got=%b exp=0000", bus.out_live); end
    checks++; if (bus.out_done !== 4'b0) begin errors++; $display("FAIL reset done got=%b exp=0000", bus.out_done); end
    checks++; if (bus.out_busy !== 4'b0) begin errors++; $display("FAIL reset busy got=%b exp=0000", bus.out_busy); end
    checks++; if (bus.out_any_live !== 1'b0) begin errors++; $display("FAIL reset any_live got=%b exp=0", bus.out_any_live); end
    checks++; if (bus.dbg_state !== 8'h00) begin errors++; $display("FAIL reset state got=%h exp=00", bus.dbg_state); end
  endtask

  task automatic test_basic();
    logic el, ed;
    set_len(0, 3); set_dly(0, 0); bus.cfg_retrig[0] = 1'b0;
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) next_cycle();
      el = (c >= 11 && c <= 22);
      ed = (c == 23);
      checks++; if (bus.out_live[0] !== el) begin errors++; $display("FAIL basic live c=%0d got=%b exp=%b", c, bus.out_live[0], el); end
      checks++; if (bus.out_done[0] !== ed) begin errors++; $display("FAIL basic done c=%0d got=%b exp=%b", c, bus.out_done[0], ed); end
      checks++; if (bus.out_busy[0] !== el) begin errors++; $display("FAIL basic busy c=%0d got=%b exp=%b", c, bus.out_busy[0], el); end
      bus.in_start[0] = (c == 10);
    end
  endtask

  task automatic test_delay();
    logic el, ed, eb;
    set_len(1, 2); set_dly(1, 5); bus.cfg_retrig[1] = 1'b0;
    for (int c = 0; c <= 31; c++) begin
      if (c > 0) next_cycle();
      eb = (c >= 1 && c <= 28);
      el = (c >= 21 && c <= 28);
      ed = (c == 29);
      checks++; if (bus.out_busy[1] !== eb) begin errors++; $display("FAIL delay busy c=%0d got=%b exp=%b", c, bus.out_busy[1], eb); end
      checks++; if (bus.out_live[1] !== el) begin errors++; $display("FAIL delay live c=%0d got=%b exp=%b", c, bus.out_live[1], el); end
      checks++; if (bus.out_done[1] !== ed) begin errors++; $display("FAIL delay done c=%0d got=%b exp=%b", c, bus.out_done[1], ed); end
      bus.in_start[1] = (c == 0);
      if (c == 5) set_len(1, 7);
    end
    set_len(1, 2);
  endtask

  task automatic test_retrig(input logic rt);
    logic el, ed;
    int   last;
    last = rt ? 26 : 16;
    set_len(2, 4); set_dly(2, 0); bus.cfg_retrig[2] = rt;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) next_cycle();
      el = (c >= 1 && c <= last);
      ed = (c == last + 1);
      checks++; if (bus.out_live[2] !== el) begin errors++; $display("FAIL retrig%0d live c=%0d got=%b exp=%b", rt, c, bus.out_live[2], el); end
      checks++; if (bus.out_done[2] !== ed) begin errors++; $display("FAIL retrig%0d done c=%0d got=%b exp=%b", rt, c, bus.out_done[2], ed); end
      bus.in_start[2] = (c == 0 || c == 10);
    end
  endtask

  task automatic test_abort();
    logic el;
    set_len(3, 10); set_dly(3, 0); bus.cfg_retrig[3] = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) next_cycle();
      el = (c >= 1 && c <= 8);
      checks++; if (bus.out_live[3] !== el) begin errors++; $display("FAIL abort live c=%0d got=%b exp=%b", c, bus.out_live[3], el); end
      checks++; if (bus.out_busy[3] !== el) begin errors++; $display("FAIL abort busy c=%0d got=%b exp=%b", c, bus.out_busy[3], el); end
      checks++; if (bus.out_done[3] !== 1'b0) begin errors++; $display("FAIL abort done c=%0d got=%b exp=0", c, bus.out_done[3]); end
      bus.in_start[3] = (c == 0);
      bus.in_abort[3] = (c == 8);
    end
    // start and abort together while idle
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) next_cycle();
      checks++; if (bus.out_busy[3] !== 1'b0 || bus.out_live[3] !== 1'b0) begin
        errors++; $display("FAIL abort_idle c=%0d busy=%b live=%b exp=0/0", c, bus.out_busy[3], bus.out_live[3]);
      end
      bus.in_start[3] = (c == 0);
      bus.in_abort[3] = (c == 0);
    end
  endtask

  task automatic test_zero_len();
    set_len(0, 0); set_dly(0, 0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle();
      checks++; if ({bus.out_busy[0], bus.out_live[0], bus.out_done[0]} !== 3'b000) begin
        errors++; $display("FAIL zero_len c=%0d busy/live/done got=%b%b%b exp=000", c, bus.out_busy[0], bus.out_live[0], bus.out_done[0]);
      end
      bus.in_start[0] = (c == 0);
    end
  endtask

  task automatic test_reset_mid();
    logic el, ed;
    set_len(0, 3); set_dly(0, 0);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_cycle();
      bus.in_start[0] = (c == 0);
    end
    checks++; if (bus.out_any_live !== 1'b1) begin errors++; $display("FAIL pre_reset any_live got=%b exp=1", bus.out_any_live); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_live !== 4'b0) begin errors++; $display("FAIL async_reset live got=%b exp=0000", bus.out_live); end
    checks++; if (bus.out_busy !== 4'b0) begin errors++; $display("FAIL async_reset busy got=%b exp=0000", bus.out_busy); end
    checks++; if (bus.out_any_live !== 1'b0) begin errors++; $display("FAIL async_reset any_live got=%b exp=0", bus.out_any_live); end
    next_cycle();
    checks++; if (bus.out_done !== 4'b0) begin errors++; $display("FAIL async_reset done got=%b exp=0000", bus.out_done); end
    rst_n = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) next_cycle();
      el = (c >= 1 && c <= 12);
      ed = (c == 13);
      checks++; if (bus.out_live[0] !== el) begin errors++; $display("FAIL post_reset live c=%0d got=%b exp=%b", c, bus.out_live[0], el); end
      checks++; if (bus.out_done[0] !== ed) begin errors++; $display("FAIL post_reset done c=%0d got=%b exp=%b", c, bus.out_done[0], ed); end
      bus.in_start[0] = (c == 0);
    end
  endtask

  task automatic test_multi();
    logic [3:0] el, ed;
    logic       ea;
    for (int i = 0; i < 4; i++) begin
      set_len(i, i + 1); set_dly(i, 0); bus.cfg_retrig[i] = 1'b0;
    end
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) next_cycle();
      for (int i = 0; i < 4; i++) begin
        el[i] = (c >= 1 && c <= 4 * (i + 1));
        ed[i] = (c == 4 * (i + 1) + 1);
      end
      ea = (c >= 2 && c <= 17);
      checks++; if (bus.out_live !== el) begin errors++; $display("FAIL multi live c=%0d got=%b exp=%b", c, bus.out_live, el); end
      checks++; if (bus.out_done !== ed) begin errors++; $display("FAIL multi done c=%0d got=%b exp=%b", c, bus.out_done, ed); end
      checks++; if (bus.out_any_live !== ea) begin errors++; $display("FAIL multi any_live c=%0d got=%b exp=%b", c, bus.out_any_live, ea); end
      bus.in_start = (c == 0) ? 4'hf : 4'h0;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.in_start   = '0;
    bus.in_abort   = '0;
    bus.cfg_length = '0;
    bus.cfg_delay  = '0;
    bus.cfg_retrig = '0;
    #3;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
    test_basic();
    test_delay();
    test_retrig(1'b1);
    test_retrig(1'b0);
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_multi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
